// File: rtl/ekf_update_seq.sv
// Sequencer around the combinational EKF update datapath: registers operands, waits a settle window, captures Xf/Pf.
// Optional posterior-to-prior feedback is enabled by defining EKF_SEQ_FEEDBACK_EN.
module ekf_update_seq #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         init_valid_i,
  input  logic [95:0]  init_xr_i,
  input  logic [95:0]  init_xi_i,
  input  logic         meas_valid_i,
  output logic         meas_ready_o,
  input  logic [47:0]  meas_zr_i,
  input  logic [47:0]  meas_zi_i,
  output logic [95:0]  dp_xr_o,
  output logic [95:0]  dp_xi_o,
  output logic [47:0]  dp_zr_o,
  output logic [47:0]  dp_zi_o,
  input  logic [191:0] dp_xf_i,
  input  logic [191:0] dp_pf_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [191:0] out_xf_o,
  output logic [191:0] out_pf_o,
  output logic         busy_o,
  output logic [15:0]  upd_count_o
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || FRAC_SHIFT > 16) begin : g_bad_param
    $error("ekf_update_seq: SETTLE_CYC must be 1..255 and FRAC_SHIFT 0..16");
  end

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_t;

  state_t         state_q;
  logic           loaded_q;
  logic [7:0]     cnt_q;
  logic [95:0]    dp_xr_q, dp_xi_q;
  logic [47:0]    dp_zr_q, dp_zi_q;
  logic           out_valid_q;
  logic [191:0]   out_xf_q, out_pf_q;
  logic [15:0]    upd_count_q;
  logic [15:0]    upd_count_d;

`ifdef EKF_SEQ_FEEDBACK_EN
  // Posterior real part, rescaled and clamped to the 16b prior format.
  logic [95:0] fb_x_d;
  for (genvar gi = 0; gi < 6; gi++) begin : g_fb
    logic signed [31:0] xf_s;
    assign xf_s = $signed(out_xf_q[32*gi +: 32]) >>> FRAC_SHIFT;
    assign fb_x_d[16*gi +: 16] = (xf_s > 32'sd32767)  ? 16'h7fff :
                                 (xf_s < -32'sd32768) ? 16'h8000 : xf_s[15:0];
  end
`endif

  assign upd_count_d  = upd_count_q + 16'd1;
  assign meas_ready_o = (state_q == IDLE) && loaded_q && !init_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      loaded_q    <= 1'b0;
      cnt_q       <= '0;
      dp_xr_q     <= '0;
      dp_xi_q     <= '0;
      dp_zr_q     <= '0;
      dp_zi_q     <= '0;
      out_valid_q <= 1'b0;
      out_xf_q    <= '0;
      out_pf_q    <= '0;
      upd_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A prior load takes precedence over a simultaneous measurement.
          if (init_valid_i) begin
            dp_xr_q  <= init_xr_i;
            dp_xi_q  <= init_xi_i;
            loaded_q <= 1'b1;
          end else if (meas_valid_i && loaded_q) begin
            dp_zr_q <= meas_zr_i;
            dp_zi_q <= meas_zi_i;
            cnt_q   <= CNT_INIT;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == 8'd0) begin
            out_xf_q    <= dp_xf_i;
            out_pf_q    <= dp_pf_i;
            out_valid_q <= 1'b1;
            state_q     <= OUTPUT;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            upd_count_q <= upd_count_d;
`ifdef EKF_SEQ_FEEDBACK_EN
            dp_xr_q     <= fb_x_d;
            dp_xi_q     <= fb_x_d;
`endif
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_xr_o     = dp_xr_q;
  assign dp_xi_o     = dp_xi_q;
  assign dp_zr_o     = dp_zr_q;
  assign dp_zi_o     = dp_zi_q;
  assign out_valid_o = out_valid_q;
  assign out_xf_o    = out_xf_q;
  assign out_pf_o    = out_pf_q;
  assign busy_o      = (state_q != IDLE);
  assign upd_count_o = upd_count_q;

endmodule
